boot_loader: RTL
================

Name: boot_loader

Overview:
Hardware program/data preloader for the single-cycle MIPS CPU. Accepts a framed byte stream over a valid/ready handshake and writes bytes, big-endian word order as delivered, into instruction or data memory through byte-wide write ports. Holds the CPU in reset while loading. Releases the CPU on a RUN frame and counts a bounded run window, replacing manual hierarchical memory pokes and fixed-cycle loops in the bench.

Parameters:
ADDR_W, 16, byte-address width of both memory write ports.
IMEM_DEPTH, 256, instruction memory size in bytes; legal addresses are 0..IMEM_DEPTH-1.
DMEM_DEPTH, 256, data memory size in bytes; legal addresses are 0..DMEM_DEPTH-1.
RUN_CYCLES, 500, clock cycles the CPU runs after RUN; 0 means run indefinitely.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  stream byte valid.
in_ready  out  1  loader can accept a byte.
in_data  in  8  stream byte.
imem_we  out  1  instruction memory byte write strobe.
dmem_we  out  1  data memory byte write strobe.
mem_addr  out  ADDR_W  byte address for the active strobe.
mem_wdata  out  8  byte to write.
cpu_reset  out  1  reset to CPU; high while loading.
running  out  1  CPU released and run window active.
done  out  1  run window expired (sticky until reset).
err  out  1  sticky framing/range error.
bytes_written  out  16  count of bytes actually written to either memory, saturating at 0xFFFF.

Behaviour:
- Reset (async, any state): FSM to HDR; in_ready=0 during reset, then 1; imem_we=dmem_we=0; mem_addr=0; mem_wdata=0; cpu_reset=1; running=0; done=0; err=0; bytes_written=0; internal counters cleared. Reset mid-frame discards the partial frame with no further writes.
- Handshake: a byte transfers on a rising edge where in_valid & in_ready. in_ready=1 in HDR, A_HI, A_LO, L_HI, L_LO, DATA; 0 in RUN and DONE. in_data ignored when not transferred.
- Frame format: header byte, addr_hi, addr_lo, len_hi, len_lo, then len payload bytes. Header 0x00 targets imem, 0x01 targets dmem, 0xFF means RUN (no further bytes).
- FSM: HDR -(0x00/0x01)-> A_HI -> A_LO -> L_HI -> L_LO -> DATA (len!=0) or HDR (len==0). DATA returns to HDR after the last payload byte. HDR -(0xFF)-> RUN. Any other header byte sets err and stays in HDR, consuming the byte.
- Address is {addr_hi,addr_lo} truncated to ADDR_W; length is 16-bit.
- Write latency: one cycle. On the edge a payload byte transfers, the selected we goes high for exactly one cycle with mem_addr=current address and mem_wdata=byte. The address then increments by 1. Back-to-back bytes give a we on consecutive cycles.
- Range: if the current address is >= the target DEPTH, the byte is consumed without a write, err is set, and the address still increments. bytes_written counts only performed writes.
- The address counter wraps modulo 2^ADDR_W. Out-of-range detection uses the wrapped value.
- RUN: cpu_reset falls and running rises on the cycle after the 0xFF byte transfers. The run counter increments every cycle in RUN. When it reaches RUN_CYCLES, in the same cycle: done=1, running=0, cpu_reset=1 (CPU frozen), and the FSM enters DONE. DONE is terminal until reset. With RUN_CYCLES=0 the FSM stays in RUN forever.
- No writes occur in RUN or DONE. imem_we and dmem_we are never high together.

Test Plan:
- Load imem frame 00 00 00 00 04 3C 01 10 01 -> imem_we pulses 4 consecutive cycles, addr 0..3, data 3C,01,10,01. bytes_written=4, err=0, cpu_reset still 1.
- Load dmem frame 01 00 1C 00 04 00 00 00 08, then FF -> dmem_we at addr 28..31 with last byte 08. Cycle after FF: cpu_reset=0, running=1. After 500 cycles: done=1, running=0, cpu_reset=1, in_ready=0.
- Range error: imem frame with addr 0x00FE, len 4, IMEM_DEPTH=256 -> writes at FE and FF only. err=1, bytes_written=2, FSM back in HDR afterward.
- Bad header 0x5A followed by a valid imem frame -> err=1. The 0x5A is consumed with no writes, and the subsequent frame writes normally.
- Zero-length frame 00 00 10 00 00 -> no strobes, returns to HDR. in_valid toggled 1/0 each cycle during payload -> writes occur only on handshake cycles.
- Assert reset during a DATA frame after 2 of 4 bytes -> all strobes drop immediately, err=0, bytes_written=0. The next frame starts from HDR.

Source files
------------

// File: rtl/boot_loader.sv
// Stream-driven preloader for the MIPS CPU memories: parses framed bytes into imem/dmem
// byte writes, holds the CPU in reset while loading, then runs it for a bounded window.
module boot_loader #(
  parameter int ADDR_W     = 16,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int RUN_CYCLES = 500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              running,
  output logic              done,
  output logic              err,
  output logic [15:0]       bytes_written
);

  typedef enum logic [2:0] {
    S_HDR, S_A_HI, S_A_LO, S_L_HI, S_L_LO, S_DATA, S_RUN, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              tgt_q, tgt_d;
  logic [7:0]        ahi_q, ahi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       len_q, len_d;
  logic [31:0]       run_q, run_d;
  logic              imem_we_q, imem_we_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       bytes_q, bytes_d;
  logic              accepting;
  logic              xfer;
  logic              in_range;

  // Every parsing state accepts bytes; RUN and DONE never do.
  assign accepting = (state_q != S_RUN) && (state_q != S_DONE);
  assign in_ready  = accepting && !reset;
  assign xfer      = in_valid && in_ready;
  assign in_range  = tgt_q ? (32'(addr_q) < 32'(DMEM_DEPTH))
                           : (32'(addr_q) < 32'(IMEM_DEPTH));

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    ahi_d       = ahi_q;
    addr_d      = addr_q;
    len_d       = len_q;
    run_d       = run_q;
    imem_we_d   = 1'b0;
    dmem_we_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    cpu_reset_d = cpu_reset_q;
    running_d   = running_q;
    done_d      = done_q;
    err_d       = err_q;
    bytes_d     = bytes_q;
    case (state_q)
      S_HDR: if (xfer) begin
        if (in_data == 8'h00 || in_data == 8'h01) begin
          tgt_d   = in_data[0];
          state_d = S_A_HI;
        end else if (in_data == 8'hFF) begin
          state_d     = S_RUN;
          cpu_reset_d = 1'b0;
          running_d   = 1'b1;
          run_d       = '0;
        end else begin
          err_d = 1'b1;
        end
      end
      S_A_HI: if (xfer) begin
        ahi_d   = in_data;
        state_d = S_A_LO;
      end
      S_A_LO: if (xfer) begin
        addr_d  = ADDR_W'({ahi_q, in_data});
        state_d = S_L_HI;
      end
      S_L_HI: if (xfer) begin
        len_d   = {in_data, 8'h00};
        state_d = S_L_LO;
      end
      S_L_LO: if (xfer) begin
        len_d   = {len_q[15:8], in_data};
        state_d = ({len_q[15:8], in_data} == 16'd0) ? S_HDR : S_DATA;
      end
      S_DATA: if (xfer) begin
        mem_addr_d = addr_q;
        wdata_d    = in_data;
        // Out-of-range bytes are swallowed but still advance the address.
        if (in_range) begin
          imem_we_d = ~tgt_q;
          dmem_we_d = tgt_q;
          if (bytes_q != 16'hFFFF) bytes_d = bytes_q + 16'd1;
        end else begin
          err_d = 1'b1;
        end
        addr_d = addr_q + ADDR_W'(1);
        len_d  = len_q - 16'd1;
        if (len_q == 16'd1) state_d = S_HDR;
      end
      S_RUN: begin
        run_d = run_q + 32'd1;
        if (RUN_CYCLES != 0 && run_d == 32'(RUN_CYCLES)) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          running_d   = 1'b0;
          cpu_reset_d = 1'b1;
        end
      end
      S_DONE: ;
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_HDR;
      tgt_q       <= 1'b0;
      ahi_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      run_q       <= '0;
      imem_we_q   <= 1'b0;
      dmem_we_q   <= 1'b0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bytes_q     <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      ahi_q       <= ahi_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      run_q       <= run_d;
      imem_we_q   <= imem_we_d;
      dmem_we_q   <= dmem_we_d;
      mem_addr_q  <= mem_addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      running_q   <= running_d;
      done_q      <= done_d;
      err_q       <= err_d;
      bytes_q     <= bytes_d;
    end
  end

  assign imem_we       = imem_we_q;
  assign dmem_we       = dmem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign running       = running_q;
  assign done          = done_q;
  assign err           = err_q;
  assign bytes_written = bytes_q;

endmodule
